// File: rtl/pwm_ramp_ctrl_pkg.sv
// Shared types, mode codes and duty-target helper for the PWM ramp controller.
// Pure declarations, no logic or latency.
// No handshake of its own.
package pwm_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RAMP     = 2'd1,
        DIV_WAIT = 2'd2
    } state_t;

    localparam logic [3:0] MODE_DUTY_0    = 4'd0;
    localparam logic [3:0] MODE_DUTY_25   = 4'd1;
    localparam logic [3:0] MODE_DUTY_50   = 4'd2;
    localparam logic [3:0] MODE_DUTY_75   = 4'd3;
    localparam logic [3:0] MODE_DUTY_100  = 4'd4;
    localparam logic [3:0] MODE_DIV_FIRST = 4'd5;

    // Quarter-scale steps of FS = 2^cnt_w; divider codes have no duty meaning.
    function automatic int duty_target(input logic [3:0] mode, input int cnt_w);
        int fs;
        fs = 1 << cnt_w;
        if (mode <= MODE_DUTY_100)
            return (fs * int'(mode)) / 4;
        else
            return 0;
    endfunction

endpackage

// File: rtl/pwm_ramp_ctrl_if.sv
// Command/strobe bundle between the mode source and the ramp controller.
// Wires only, no latency.
// mode_valid/mode_ready handshake; period_end is an unqualified strobe.
interface pwm_ramp_ctrl_if #(parameter int CNT_W = 5);
    logic [3:0]     mode;
    logic           mode_valid;
    logic           mode_ready;
    logic           period_end;
    logic [CNT_W:0] width;
    logic [3:0]     div_sel;
    logic           busy;
    logic           done;

    modport master (
        output mode, mode_valid, period_end,
        input  mode_ready, width, div_sel, busy, done
    );

    modport slave (
        input  mode, mode_valid, period_end,
        output mode_ready, width, div_sel, busy, done
    );
endinterface

// File: rtl/pwm_ramp_ctrl_dwell_counter.sv
// Counts period_end strobes and fires step on every HOLD_PERIODS-th one.
// step is combinational with the qualifying period_end (0 cycles).
// No backpressure; clr holds the count at zero and masks step.
module pwm_dwell_counter #(
    parameter int HOLD_PERIODS = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic period_end,
    output logic step
);
    localparam int CW = (HOLD_PERIODS > 1) ? $clog2(HOLD_PERIODS) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_PERIODS - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign step = period_end && !clr && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (period_end)
            cnt_d = step ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end
endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Ramps PWM width toward a commanded duty and applies divider changes at period boundaries.
// Width step lands 1 cycle after the qualifying period_end; equal-target commands finish 1 cycle after accept.
// mode_ready low while a command is in flight and during its done cycle; source must hold mode_valid.
module pwm_ramp_ctrl
    import pwm_pkg::*;
#(
    parameter int CNT_W        = 5,
    parameter int RAMP_STEP    = 4,
    parameter int HOLD_PERIODS = 2
) (
    input logic            clk,
    input logic            rst,
    pwm_ramp_ctrl_if.slave bus
);
    localparam int W = CNT_W + 1;
    localparam logic [W-1:0] STEP = W'(RAMP_STEP);

    state_t         state_q, state_d;
    logic [W-1:0]   width_q, width_d;
    logic [W-1:0]   target_q, target_d;
    logic [3:0]     div_sel_q, div_sel_d;
    logic [3:0]     div_pend_q, div_pend_d;
    logic           done_q, done_d;
    logic [W-1:0]   mode_tgt;
    logic [W-1:0]   step_w;
    logic           accept;
    logic           dwell_step;
    logic           dwell_clr;

    assign mode_tgt = W'(duty_target(bus.mode, CNT_W));
    assign accept   = bus.mode_valid && bus.mode_ready;

    // Outside RAMP the counter is held clear, so a period_end on the accept cycle is never counted.
    assign dwell_clr = (state_q != RAMP);

    pwm_dwell_counter #(.HOLD_PERIODS(HOLD_PERIODS)) u_dwell (
        .clk        (clk),
        .rst        (rst),
        .clr        (dwell_clr),
        .period_end (bus.period_end),
        .step       (dwell_step)
    );

    // Clamp to target when within one step so the ramp never overshoots.
    always_comb begin
        if (target_q > width_q)
            step_w = ((target_q - width_q) <= STEP) ? target_q : width_q + STEP;
        else
            step_w = ((width_q - target_q) <= STEP) ? target_q : width_q - STEP;
    end

    always_comb begin
        state_d    = state_q;
        width_d    = width_q;
        target_d   = target_q;
        div_sel_d  = div_sel_q;
        div_pend_d = div_pend_q;
        done_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.mode >= MODE_DIV_FIRST) begin
                        div_pend_d = bus.mode - 4'd4;
                        state_d    = DIV_WAIT;
                    end else begin
                        target_d = mode_tgt;
                        if (mode_tgt == width_q)
                            done_d = 1'b1;
                        else
                            state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (dwell_step) begin
                    width_d = step_w;
                    if (step_w == target_q) begin
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            DIV_WAIT: begin
                if (bus.period_end) begin
                    div_sel_d = div_pend_q;
                    done_d    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            width_q    <= '0;
            target_q   <= '0;
            div_sel_q  <= '0;
            div_pend_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            width_q    <= width_d;
            target_q   <= target_d;
            div_sel_q  <= div_sel_d;
            div_pend_q <= div_pend_d;
            done_q     <= done_d;
        end
    end

    assign bus.mode_ready = (state_q == IDLE) && !done_q;
    assign bus.width      = width_q;
    assign bus.div_sel    = div_sel_q;
    assign bus.busy       = (state_q != IDLE);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Scoreboard bench for pwm_ramp_ctrl: directed scenarios followed by random commands.
// Expected output events come from a duty/step/period model, checked by an independent monitor.
module tb_pwm_ramp_ctrl;
    localparam int FS    = 32;
    localparam int STEP  = 4;
    localparam int HOLD  = 2;
    localparam int PER   = 32;

    typedef struct {
        int w;
        int d;
        int dn;
        int pe;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    pwm_ramp_ctrl_if #(.CNT_W(5)) bus ();

    pwm_ramp_ctrl #(.CNT_W(5), .RAMP_STEP(STEP), .HOLD_PERIODS(HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int  checks   = 0;
    int  failures = 0;
    ev_t q[$];
    int  m_width  = 0;
    int  m_div    = 0;
    int  pe_cnt   = 0;
    int  prev_w   = 0;
    int  prev_d   = 0;
    bit  in_rst   = 1'b1;
    int  pcnt     = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Expected output events of one accepted command, from the duty/step/period rules.
    task automatic model_push(input int m);
        ev_t e;
        int  t, w, k;
        if (m >= 5) begin
            m_div = m - 4;
            e = '{m_width, m_div, 1, 1};
            q.push_back(e);
        end else begin
            t = m * FS / 4;
            if (t == m_width) begin
                e = '{m_width, m_div, 1, 0};
                q.push_back(e);
            end else begin
                w = m_width;
                k = 0;
                while (w != t) begin
                    k++;
                    if (t > w) w = (w + STEP < t) ? w + STEP : t;
                    else       w = (w - STEP > t) ? w - STEP : t;
                    e = '{w, m_div, (w == t) ? 1 : 0, HOLD * k};
                    q.push_back(e);
                end
                m_width = t;
            end
        end
    endtask

    // Period generator: one-cycle strobe every PER cycles.
    initial begin
        bus.period_end = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            pcnt = (pcnt + 1) % PER;
            bus.period_end = (pcnt == 0);
        end
    end

    // Monitor: outputs reflect the edge just passed; inputs are those for the next edge.
    always @(negedge clk) begin
        ev_t e;
        bit  chg;
        if (in_rst) begin
            chk("rst_width", int'(bus.width), 0);
            chk("rst_div_sel", int'(bus.div_sel), 0);
            chk("rst_busy", int'(bus.busy), 0);
            chk("rst_ready", int'(bus.mode_ready), 1);
            chk("rst_done", int'(bus.done), 0);
            q.delete();
            m_width = 0;
            m_div   = 0;
            pe_cnt  = 0;
        end else begin
            chg = bus.done || (int'(bus.width) != prev_w) || (int'(bus.div_sel) != prev_d);
            chk("mode_ready", int'(bus.mode_ready), (q.size() == 0 && !bus.done) ? 1 : 0);
            chk("busy", int'(bus.busy), (q.size() != 0 && !bus.done) ? 1 : 0);
            if (chg) begin
                if (q.size() == 0) begin
                    chk("unexpected_event_width", int'(bus.width), prev_w);
                end else begin
                    e = q.pop_front();
                    chk("ev_width", int'(bus.width), e.w);
                    chk("ev_div_sel", int'(bus.div_sel), e.d);
                    chk("ev_done", int'(bus.done), e.dn);
                    chk("ev_period_count", pe_cnt, e.pe);
                end
            end
        end
        prev_w = int'(bus.width);
        prev_d = int'(bus.div_sel);
        in_rst = rst;
        if (!rst) begin
            if (bus.mode_valid && bus.mode_ready) begin
                pe_cnt = 0;
                model_push(int'(bus.mode));
            end else if (bus.period_end) begin
                pe_cnt++;
            end
        end
    end

    task automatic issue(input logic [3:0] m, input bit on_pe);
        int n;
        n = 0;
        @(posedge clk);
        #2;
        if (on_pe) begin
            while (!bus.period_end && n < 2 * PER) begin
                @(posedge clk);
                #2;
                n++;
            end
        end
        bus.mode = m;
        bus.mode_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.mode_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", n, 0);
        @(posedge clk);
        #2;
        bus.mode_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while ((q.size() != 0 || !bus.mode_ready) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) chk("idle_timeout", n, 0);
    endtask

    initial begin
        int n;
        bus.mode = 4'd0;
        bus.mode_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        issue(4'd2, 1'b0); wait_idle();    // 0 -> 16
        issue(4'd0, 1'b0); wait_idle();    // 16 -> 0
        issue(4'd3, 1'b0); wait_idle();    // 0 -> 24
        issue(4'd3, 1'b0); wait_idle();    // equal target
        issue(4'd7, 1'b0); wait_idle();    // div_sel -> 3
        issue(4'd0, 1'b0); wait_idle();
        issue(4'd4, 1'b1); wait_idle();    // accepted on a period_end
        issue(4'd0, 1'b0); wait_idle();

        // Reset mid-ramp at width 12.
        issue(4'd2, 1'b0);
        n = 0;
        while (bus.width != 6'd12 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) chk("width12_timeout", n, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;

        // Second command held off while the first is busy.
        issue(4'd2, 1'b0);
        issue(4'd7, 1'b0);
        wait_idle();

        for (int i = 0; i < 24; i++) begin
            issue(4'($urandom_range(0, 15)), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) wait_idle();
            repeat ($urandom_range(0, 20)) @(posedge clk);
        end
        wait_idle();
        repeat (4) @(posedge clk);
        chk("queue_drained", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
